// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD add/subtract unit with lane widths of 8 bits up to the full vector.
// Stage 1 captures the operands, with the immediate already expanded to the lane width.
// Stage 2 does the per-lane arithmetic, saturation and overflow flags.
// Both stages advance together whenever the output register is empty or being drained.
module simd_addsub_pipe #(
  parameter int SIMD_WIDTH = 256,
  parameter int NUM_MODES  = 6,
  parameter int FLAG_W     = SIMD_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIMD_WIDTH-1:0] A,
  input  logic [SIMD_WIDTH-1:0] B,
  input  logic [2:0]            data_mode,
  input  logic                  sub_flag,
  input  logic                  imm_flag,
  input  logic [7:0]            imm_reg,
  input  logic [1:0]            sat_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIMD_WIDTH-1:0] out,
  output logic [FLAG_W-1:0]     out_ovf,
  output logic                  out_err
);

  logic                  en;

  logic                  s1_valid_q, s1_valid_d;
  logic [SIMD_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [SIMD_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]            s1_mode_q, s1_mode_d;
  logic                  s1_sub_q, s1_sub_d;
  logic [1:0]            s1_sat_q, s1_sat_d;

  logic                  out_valid_q, out_valid_d;
  logic [SIMD_WIDTH-1:0] out_q, out_d;
  logic [FLAG_W-1:0]     out_ovf_q, out_ovf_d;
  logic                  out_err_q, out_err_d;

  // Immediate replicated per lane width, and per-width arithmetic results.
  logic [SIMD_WIDTH-1:0] imm_rep [NUM_MODES];
  logic [SIMD_WIDTH-1:0] res_m   [NUM_MODES];
  logic [FLAG_W-1:0]     ovf_m   [NUM_MODES];

  // A single enable stalls the whole pipe; a stalled output frees nothing upstream.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_MODES; gi++) begin : g_mode
      localparam int W = 8 << gi;
      localparam int N = SIMD_WIDTH / W;
      logic [SIMD_WIDTH-1:0] res_v;
      logic [FLAG_W-1:0]     ovf_v;

      // Sign-extend the immediate to one lane and copy it into every lane.
      if (gi == 0) begin : g_imm8
        assign imm_rep[gi] = {N{imm_reg}};
      end else begin : g_immw
        assign imm_rep[gi] = {N{ {{(W-8){imm_reg[7]}}, imm_reg} }};
      end

      for (gj = 0; gj < N; gj++) begin : g_lane
        logic [W-1:0] la, lb, raw, lres;
        logic [W:0]   sum;
        logic         sovf, uovf, lovf;

        // Subtraction is A + ~op + 1; the +1 enters as this lane's own carry-in,
        // so nothing propagates from the neighbouring lane.
        assign la   = s1_a_q[gj*W +: W];
        assign lb   = s1_sub_q ? ~s1_b_q[gj*W +: W] : s1_b_q[gj*W +: W];
        assign sum  = {1'b0, la} + {1'b0, lb} + {{W{1'b0}}, s1_sub_q};
        assign raw  = sum[W-1:0];
        assign sovf = (la[W-1] == lb[W-1]) && (raw[W-1] != la[W-1]);
        // Carry out on add, or no carry out (a borrow) on subtract.
        assign uovf = s1_sub_q ? !sum[W] : sum[W];

        // Pick the lane result and flag for the selected saturation mode.
        always_comb begin
          lres = raw;
          lovf = sovf;
          case (s1_sat_q)
            2'd1: begin
              if (sovf) begin
                lres = la[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
              end
            end
            2'd2: begin
              lovf = uovf;
              if (uovf) begin
                lres = s1_sub_q ? {W{1'b0}} : {W{1'b1}};
              end
            end
            default: ;
          endcase
        end

        assign res_v[gj*W +: W]         = lres;
        assign ovf_v[gj*(W/8) +: (W/8)] = {(W/8){lovf}};
      end

      assign res_m[gi] = res_v;
      assign ovf_m[gi] = ovf_v;
    end
  endgenerate

  // Stage 1 next state: capture operands, substituting the expanded immediate for B.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_sub_d   = s1_sub_q;
    s1_sat_d   = s1_sat_q;
    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = A;
        s1_b_d    = B;
        s1_mode_d = data_mode;
        s1_sub_d  = sub_flag;
        s1_sat_d  = sat_mode;
        if (imm_flag) begin
          for (int m = 0; m < NUM_MODES; m++) begin
            if (data_mode == 3'(m)) s1_b_d = imm_rep[m];
          end
        end
      end
    end
  end

  // Stage 2 next state: select the lane-width result; unknown widths give zero plus error.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d     = '0;
        out_ovf_d = '0;
        out_err_d = 1'b1;
        for (int m = 0; m < NUM_MODES; m++) begin
          if (s1_mode_q == 3'(m)) begin
            out_d     = res_m[m];
            out_ovf_d = ovf_m[m];
            out_err_d = 1'b0;
          end
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s1_sub_q    <= 1'b0;
      s1_sat_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_sub_q    <= s1_sub_d;
      s1_sat_q    <= s1_sat_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Testbench for simd_addsub_pipe: directed cases, back-pressure, reset drop and a random
// stream, all scored against an integer-arithmetic lane model.
module tb_simd_addsub_pipe;

  typedef struct packed {
    logic [255:0] a;
    logic [255:0] b;
    logic [2:0]   mode;
    logic         sub;
    logic         immf;
    logic [7:0]   imm;
    logic [1:0]   sat;
  } beat_t;

  typedef struct packed {
    logic [255:0] r;
    logic [31:0]  f;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] A = '0;
  logic [255:0] B = '0;
  logic [2:0]   data_mode = '0;
  logic         sub_flag = 1'b0;
  logic         imm_flag = 1'b0;
  logic [7:0]   imm_reg = '0;
  logic [1:0]   sat_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out;
  logic [31:0]  out_ovf;
  logic         out_err;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_consumed = 0;
  exp_t exp_q[$];
  beat_t idle_bt;

  always #5 clk = ~clk;

  simd_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .data_mode(data_mode), .sub_flag(sub_flag), .imm_flag(imm_flag),
    .imm_reg(imm_reg), .sat_mode(sat_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_ovf(out_ovf), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Lane-by-lane reference using whole-number arithmetic and explicit range tests.
  function automatic exp_t model(input beat_t bt);
    exp_t e;
    int w, n;
    logic signed [259:0] ua, ub, sa, sb, t, pow, half;
    logic ovf;
    e = '0;
    if (bt.mode > 3'd5) begin
      e.e = 1'b1;
      return e;
    end
    w = 8 << bt.mode;
    n = 256 / w;
    pow = 1;
    pow = pow << w;
    half = pow >>> 1;
    for (int l = 0; l < n; l++) begin
      ua = '0;
      ub = '0;
      for (int k = 0; k < w; k++) begin
        ua[k] = bt.a[l*w+k];
        ub[k] = bt.immf ? bt.imm[(k < 8) ? k : 7] : bt.b[l*w+k];
      end
      sa = ua[w-1] ? ua - pow : ua;
      sb = ub[w-1] ? ub - pow : ub;
      if (bt.sat == 2'd2) begin
        t = bt.sub ? ua - ub : ua + ub;
        ovf = (t < 0) || (t >= pow);
        if (t < 0) t = 0;
        else if (t >= pow) t = pow - 1;
      end else begin
        t = bt.sub ? sa - sb : sa + sb;
        ovf = (t >= half) || (t < -half);
        if (bt.sat == 2'd1 && ovf) t = (t > 0) ? half - 1 : -half;
      end
      for (int k = 0; k < w; k++) e.r[l*w+k] = t[k];
      if (ovf) for (int k = 0; k < w/8; k++) e.f[l*(w/8)+k] = 1'b1;
    end
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, score the output just after, and
  // record what the coming rising edge will accept or consume.
  task automatic drive_cycle(input logic r, input logic v, input beat_t bt,
                             input logic ordy, output logic acc);
    exp_t ex;
    @(negedge clk);
    rst = r;
    in_valid = v;
    A = bt.a;
    B = bt.b;
    data_mode = bt.mode;
    sub_flag = bt.sub;
    imm_flag = bt.immf;
    imm_reg = bt.imm;
    sat_mode = bt.sat;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready && !rst;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        ex = exp_q[0];
        chk("sb_out", out, ex.r);
        chk("sb_ovf", out_ovf, ex.f);
        chk("sb_err", out_err, ex.e);
        if (out_ready && !rst) begin
          void'(exp_q.pop_front());
          n_consumed++;
        end
      end
    end
    if (rst) exp_q.delete();
    else if (acc) exp_q.push_back(model(bt));
  endtask

  // Single isolated beat with fixed expected result and two-cycle latency.
  task automatic send_directed(input string tag, input beat_t bt, input logic [255:0] eo,
                               input logic [31:0] ef, input logic ee);
    logic acc;
    drive_cycle(0, 1, bt, 1, acc);
    chk({tag, "_acc"}, acc, 1);
    drive_cycle(0, 0, idle_bt, 1, acc);
    chk({tag, "_lat1"}, out_valid, 0);
    drive_cycle(0, 0, idle_bt, 1, acc);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_ovf"}, out_ovf, ef);
    chk({tag, "_err"}, out_err, ee);
    $display("directed %s: out=%h ovf=%h err=%b", tag, out, out_ovf, out_err);
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    case ($urandom_range(0, 5))
      0: v = '1;
      1: v = '0;
      2: v = {32{8'h7f}};
      3: v = {32{8'h80}};
      default: for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    bt.a = rand_vec();
    bt.b = rand_vec();
    bt.mode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    bt.sub = 1'($urandom);
    bt.immf = ($urandom_range(0, 3) == 0);
    bt.imm = 8'($urandom);
    bt.sat = 2'($urandom);
    return bt;
  endfunction

  initial begin
    beat_t bt;
    beat_t bp_beats[4];
    logic acc;
    int idx, c;

    idle_bt = '0;

    // Reset state
    drive_cycle(1, 0, idle_bt, 0, acc);
    drive_cycle(1, 1, idle_bt, 1, acc);
    drive_cycle(0, 0, idle_bt, 1, acc);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_err", out_err, 0);

    // 8-bit wrap add; lane 0 wraps without signed overflow
    bt = '0;
    bt.a = {{31{8'h10}}, 8'hff};
    bt.b = {{31{8'h20}}, 8'h01};
    send_directed("add8_wrap", bt, {{31{8'h30}}, 8'h00}, 32'h0, 1'b0);

    // 16-bit signed saturate
    bt = '0;
    bt.mode = 3'd1;
    bt.sat = 2'd1;
    bt.a = {16{16'h7fff}};
    bt.b = {16{16'h0001}};
    send_directed("ssat16", bt, {16{16'h7fff}}, 32'hffffffff, 1'b0);

    // 16-bit unsigned saturate subtract
    bt = '0;
    bt.mode = 3'd1;
    bt.sat = 2'd2;
    bt.sub = 1'b1;
    bt.b = {16{16'h0005}};
    send_directed("usat16_sub", bt, 256'h0, 32'hffffffff, 1'b0);

    // Immediate subtract of -1 in 32-bit lanes
    bt = '0;
    bt.mode = 3'd2;
    bt.sub = 1'b1;
    bt.immf = 1'b1;
    bt.imm = 8'hff;
    bt.b = {32{8'h5a}};
    send_directed("imm32_sub", bt, {8{32'h00000001}}, 32'h0, 1'b0);

    // Full-width add: carry ripples across the whole vector
    bt = '0;
    bt.mode = 3'd5;
    bt.a = '1;
    bt.b = 256'd1;
    send_directed("add256", bt, 256'h0, 32'h0, 1'b0);

    // Same operands in 8-bit lanes: only byte 0 sees the +1, and its carry must not leak
    bt.mode = 3'd0;
    send_directed("add8_noleak", bt, {{31{8'hff}}, 8'h00}, 32'h0, 1'b0);

    // Back-pressure: four beats, consumer stalls in cycles 3..5
    for (int i = 0; i < 4; i++) bp_beats[i] = rand_beat();
    for (int i = 0; i < 4; i++) bp_beats[i].mode = 3'(i);
    n_consumed = 0;
    idx = 0;
    c = 1;
    while ((idx < 4 || exp_q.size() != 0) && c < 30) begin
      drive_cycle(0, idx < 4, (idx < 4) ? bp_beats[idx] : idle_bt, !(c >= 3 && c <= 5), acc);
      if (c >= 3 && c <= 5) chk("bp_in_ready", in_ready, 0);
      if (acc) idx++;
      c++;
    end
    chk("bp_accepted", 256'(idx), 256'd4);
    chk("bp_consumed", 256'(n_consumed), 256'd4);
    $display("backpressure: accepted=%0d consumed=%0d cycles=%0d", idx, n_consumed, c - 1);

    // Illegal width beat, then reset with another beat in flight
    bt = rand_beat();
    bt.mode = 3'd6;
    drive_cycle(0, 1, bt, 0, acc);
    chk("err_acc", acc, 1);
    bt = rand_beat();
    bt.mode = 3'd2;
    drive_cycle(0, 1, bt, 0, acc);
    drive_cycle(1, 0, idle_bt, 0, acc);
    chk("err_valid", out_valid, 1);
    chk("err_out", out, 0);
    chk("err_flag", out_err, 1);
    $display("illegal mode: out_err=%b out=%h", out_err, out);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, idle_bt, 1, acc);
      chk("post_rst_valid", out_valid, 0);
    end

    // Random stream with random stalls on both sides
    for (int i = 0; i < 400; i++) begin
      bt = rand_beat();
      drive_cycle(0, $urandom_range(0, 9) < 7, bt, $urandom_range(0, 9) < 7, acc);
      if (acc) $display("beat %0d: mode=%0d sub=%b imm=%b sat=%0d", i, bt.mode, bt.sub, bt.immf, bt.sat);
    end
    c = 0;
    while (exp_q.size() != 0 && c < 20) begin
      drive_cycle(0, 0, idle_bt, 1, acc);
      c++;
    end
    chk("drain_empty", 256'(exp_q.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
